// File: rtl/idli_sqi_ctl_m.sv
// idli_sqi_ctl_m: shares the SQI stream between fetch and load/store, sequencing 4-GCK beats
module idli_sqi_ctl_m #(
    parameter int HDR_BEATS = 5
) (
    input  logic        i_ctl_gck,
    input  logic        i_ctl_rst_n,
    input  logic [1:0]  i_ctl_ctr,
    input  logic        i_ctl_br_req,
    input  logic [15:0] i_ctl_br_addr,
    output logic        o_ctl_br_ack,
    input  logic        i_ctl_mem_req,
    input  logic        i_ctl_mem_wr,
    input  logic [15:0] i_ctl_mem_addr,
    input  logic [15:0] i_ctl_mem_wdata,
    input  logic [15:0] i_ctl_pc,
    output logic        o_ctl_mem_ack,
    output logic [15:0] o_ctl_ld_data,
    output logic        o_ctl_ld_vld,
    input  logic        i_ctl_fetch_stall,
    output logic [15:0] o_ctl_instr,
    output logic        o_ctl_instr_vld,
    output logic        o_ctl_busy,
    output logic        o_ctl_sqi_redirect,
    output logic        o_ctl_sqi_wr_en,
    output logic        o_ctl_sqi_stall,
    output logic [3:0]  o_ctl_sqi_slice,
    input  logic [15:0] i_ctl_sqi_instr,
    input  logic        i_ctl_sqi_instr_vld,
    input  logic        i_ctl_sqi_wr_acp
);
    localparam int CW = $clog2(HDR_BEATS + 1);

    typedef enum logic [1:0] {S_HDR, S_FETCH, S_REDIR, S_XFER} state_t;
    typedef enum logic [1:0] {K_FETCH, K_BR, K_LD, K_ST} kind_t;

    state_t        r_state, w_state;
    kind_t         r_kind, w_kind;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [15:0]   r_target, w_target, r_wdata, w_wdata, r_pc, w_pc;
    logic [3:0]    w_sh;
    logic          w_beat, w_last;

    assign w_sh       = {i_ctl_ctr, 2'b00};
    assign w_beat     = i_ctl_ctr == 2'd3;
    assign w_last     = r_cnt == CW'(HDR_BEATS - 1);
    assign o_ctl_busy = r_state != S_FETCH;

    always_ff @(posedge i_ctl_gck or negedge i_ctl_rst_n) begin
        if (!i_ctl_rst_n) begin
            r_state  <= S_HDR;
            r_kind   <= K_FETCH;
            r_cnt    <= '0;
            r_target <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
        end else begin
            r_state  <= w_state;
            r_kind   <= w_kind;
            r_cnt    <= w_cnt;
            r_target <= w_target;
            r_wdata  <= w_wdata;
            r_pc     <= w_pc;
        end
    end

    always_comb begin
        w_state            = r_state;
        w_kind             = r_kind;
        w_cnt              = r_cnt;
        w_target           = r_target;
        w_wdata            = r_wdata;
        w_pc               = r_pc;
        o_ctl_br_ack       = 1'b0;
        o_ctl_mem_ack      = 1'b0;
        o_ctl_ld_data      = 16'h0;
        o_ctl_ld_vld       = 1'b0;
        o_ctl_instr        = 16'h0;
        o_ctl_instr_vld    = 1'b0;
        o_ctl_sqi_redirect = 1'b0;
        o_ctl_sqi_wr_en    = 1'b0;
        o_ctl_sqi_stall    = 1'b0;
        o_ctl_sqi_slice    = 4'h0;
        case (r_state)
            S_HDR: begin
                o_ctl_sqi_wr_en = r_kind == K_ST;
                // store data starts streaming in the last header beat
                o_ctl_sqi_slice = (w_last && r_kind == K_ST) ? r_wdata[w_sh +: 4] : 4'h0;
                if (w_beat) begin
                    w_cnt   = w_last ? '0 : r_cnt + 1'b1;
                    w_state = !w_last ? S_HDR : (r_kind == K_LD || r_kind == K_ST) ? S_XFER : S_FETCH;
                end
            end
            S_FETCH: begin
                o_ctl_instr     = i_ctl_sqi_instr;
                o_ctl_instr_vld = i_ctl_sqi_instr_vld && !i_ctl_fetch_stall;
                o_ctl_sqi_stall = i_ctl_fetch_stall;
                // load/store beats a branch; the branch stays pending until fetch resumes
                if (w_beat && !i_ctl_fetch_stall && (i_ctl_mem_req || i_ctl_br_req)) begin
                    w_state  = S_REDIR;
                    w_kind   = i_ctl_mem_req ? (i_ctl_mem_wr ? K_ST : K_LD) : K_BR;
                    w_target = i_ctl_mem_req ? i_ctl_mem_addr : i_ctl_br_addr;
                    w_wdata  = i_ctl_mem_wdata;
                    w_pc     = i_ctl_pc;
                end
            end
            S_REDIR: begin
                o_ctl_sqi_redirect = 1'b1;
                o_ctl_sqi_slice    = r_target[w_sh +: 4];
                o_ctl_sqi_wr_en    = r_kind == K_ST;
                o_ctl_br_ack       = w_beat && r_kind == K_BR;
                if (w_beat) begin
                    w_state = S_HDR;
                    w_cnt   = '0;
                end
            end
            default: begin
                o_ctl_ld_data   = r_kind == K_LD ? i_ctl_sqi_instr : 16'h0;
                o_ctl_ld_vld    = w_beat && r_kind == K_LD;
                o_ctl_sqi_wr_en = r_kind == K_ST;
                o_ctl_sqi_slice = r_kind == K_ST ? r_wdata[w_sh +: 4] : 4'h0;
                o_ctl_mem_ack   = w_beat;
                if (w_beat) begin
                    w_state  = S_REDIR;
                    w_kind   = K_FETCH;
                    w_target = r_pc;
                end
            end
        endcase
    end

    a_store_acp: assert property (@(posedge i_ctl_gck) disable iff (!i_ctl_rst_n)
        (r_state == S_HDR && w_last && r_kind == K_ST && w_beat) |-> i_ctl_sqi_wr_acp);
endmodule
